serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor that computes diff = a - b - bin over N clock cycles, LSB first. It is the inverse arithmetic counterpart of the combinational N-bit adder. It replaces a wide combinational borrow chain with a one-bit full subtractor, a shift register and a small FSM. Client logic drives it with a start/done handshake.

---
 rtl/serial_subtractor_if.sv | 39 +++
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake bundle between a client
// and the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;

    modport master (
        output start,
        output a,
        output b,
        output bin,
        input  busy,
        input  done,
        input  diff,
        input  bout,
        input  ovf
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  bin,
        output busy,
        output done,
        output diff,
        output bout,
        output ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b - bin one bit per clock, LSB first,
// using a one-bit full subtractor, shift registers and an IDLE/RUN FSM.
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_br;
    logic          r_a_msb;
    logic          r_b_msb;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_res;

    logic [N-1:0]  r_diff;
    logic          r_bout;
    logic          r_ovf;
    logic          r_done;

    logic          w_accept;
    logic          w_run;
    logic          w_last;
    logic          w_ai;
    logic          w_bi;
    logic          w_d;
    logic          w_br_next;
    logic [N-1:0]  w_res_next;
    logic          w_ovf;

    // One-bit full subtractor on the current LSBs of the operand shifters.
    always_comb begin
        w_ai       = r_a[0];
        w_bi       = r_b[0];
        w_d        = w_ai ^ w_bi ^ r_br;
        w_br_next  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
        w_res_next = {w_d, r_res[N-1:1]};
        w_ovf      = (r_a_msb ^ r_b_msb) & (w_res_next[N-1] ^ r_a_msb);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_run        = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_run = 1'b1;
                if (r_cnt == CW'(N - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    // Operand capture and per-bit shifting of operands, borrow and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_br    <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_br    <= bus.bin;
            r_a_msb <= bus.a[N-1];
            r_b_msb <= bus.b[N-1];
            r_cnt   <= '0;
            r_res   <= '0;
        end else if (w_run) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_next;
            r_res <= w_res_next;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Result registers update only on the edge that finishes the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_diff <= w_res_next;
                r_bout <= w_br_next;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors, expected results queued at
// issue time and checked by a monitor whenever done is seen.
module tb_serial_subtractor;

    logic clk;
    logic rst;

    serial_subtractor_if #(.N(8)) sif ();

    serial_subtractor #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest entry.
    always @(negedge clk) begin
        if (!rst && sif.done) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got diff=%0h want none",
                         sif.diff);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", int'(sif.diff), int'(e.d));
                chk("bout", int'(sif.bout), int'(e.bo));
                chk("ovf", int'(sif.ovf), int'(e.ov));
            end
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (sif.done) begin
                lat = i;
                break;
            end
        end
    endtask

    // Issue one op (may be called in a done cycle for back-to-back).
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          input logic ibin, input logic [7:0] ed,
                          input logic eb, input logic eo);
        int lat;
        sif.start = 1'b1;
        sif.a     = ia;
        sif.b     = ib;
        sif.bin   = ibin;
        q.push_back('{ed, eb, eo});
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        chk("busy_after_accept", int'(sif.busy), 1);
        wait_done(lat);
        chk("latency", lat, 8);
        chk("busy_at_done", int'(sif.busy), 0);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        sif.start = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        sif.bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(sif.busy), 0);
        chk("rst_done", int'(sif.done), 0);
        chk("rst_diff", int'(sif.diff), 0);
        chk("rst_bout", int'(sif.bout), 0);
        chk("rst_ovf", int'(sif.ovf), 0);

        // rst wins over start on the same edge
        sif.start = 1'b1;
        sif.a     = 8'd50;
        sif.b     = 8'd20;
        @(posedge clk);
        #1;
        chk("rst_over_start", int'(sif.busy), 0);
        rst       = 1'b0;
        sif.start = 1'b0;
        @(posedge clk);
        #1;

        run_op(8'd50, 8'd20, 1'b0, 8'h1E, 1'b0, 1'b0);
        run_op(8'd10, 8'd20, 1'b0, 8'hF6, 1'b1, 1'b0);
        run_op(8'd0, 8'd0, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", int'(sif.done), 0);
        chk("diff_hold", int'(sif.diff), 8'h80);

        // start held high while busy must be ignored
        sif.start = 1'b1;
        sif.a     = 8'd100;
        sif.b     = 8'd1;
        sif.bin   = 1'b0;
        q.push_back('{8'h63, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        sif.a = 8'd5;
        sif.b = 8'd7;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        sif.start = 1'b0;
        wait_done(lat);
        chk("ignore_start_latency", lat, 1);
        @(posedge clk);
        #1;
        chk("no_restart_busy", int'(sif.busy), 0);
        chk("no_restart_done", int'(sif.done), 0);
        chk("hold_63", int'(sif.diff), 8'h63);

        // back-to-back: second start lands in the done cycle
        run_op(8'd10, 8'd3, 1'b0, 8'h07, 1'b0, 1'b0);
        run_op(8'd3, 8'd10, 1'b0, 8'hF9, 1'b1, 1'b0);

        // abort with rst at cycle 4 of RUN
        sif.start = 1'b1;
        sif.a     = 8'hAA;
        sif.b     = 8'h55;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", int'(sif.busy), 0);
        chk("abort_done", int'(sif.done), 0);
        chk("abort_diff", int'(sif.diff), 0);
        chk("abort_bout", int'(sif.bout), 0);
        chk("abort_ovf", int'(sif.ovf), 0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_idle", int'(sif.busy), 0);

        run_op(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
